// File: rtl/spi_slave_core_pkg.sv
// rtl/spi_slave_core_pkg.sv - shared state type and counter sizing for the SPI slave core
package spi_slave_core_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int WIDTH_DEFAULT = 8;
  localparam int CNT_W = $clog2(WIDTH_DEFAULT + 1);

  // Bit counter must hold 0..WIDTH.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/spi_slave_core_sync_debounce.sv
// rtl/spi_slave_core_sync_debounce.sv - sync_debounce: 2-flop synchroniser plus stability counter
// Produces a conditioned level and single-cycle rise/fall pulses aligned with its change.
module sync_debounce #(
  parameter int   DEBOUNCE  = 3,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic       s1;
  logic       s2;
  logic [7:0] cnt;

  // Sync flops start at the conditioned reset value so release never looks like an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= RESET_VAL;
      s2   <= RESET_VAL;
      cnt  <= 8'd0;
      dout <= RESET_VAL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      rise <= 1'b0;
      fall <= 1'b0;
      if (s2 == dout) begin
        cnt <= 8'd0;
      end else if (cnt == 8'(DEBOUNCE - 1)) begin
        dout <= s2;
        rise <= s2;
        fall <= ~s2;
        cnt  <= 8'd0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/spi_slave_core.sv
// rtl/spi_slave_core.sv - SPI slave with conditioned inputs, pending transmit load
// Optional feature macro: SPI_SLAVE_CORE_LOOPBACK_EN (received word reloads the transmit register).
module spi_slave_core
  import spi_slave_core_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEBOUNCE  = 3,
  parameter int CPHA      = 0,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sclk_raw,
  input  logic             mosi_raw,
  input  logic             cs_n_raw,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic             miso,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);

  logic sclk_c, sclk_rise, sclk_fall;
  logic mosi_c, mosi_rise, mosi_fall;
  logic cs_n_c, cs_rise, cs_fall;

  sync_debounce #(.DEBOUNCE(DEBOUNCE), .RESET_VAL(1'b0)) u_sclk (
    .clk(clk), .reset(reset), .din(sclk_raw), .dout(sclk_c), .rise(sclk_rise), .fall(sclk_fall)
  );
  sync_debounce #(.DEBOUNCE(DEBOUNCE), .RESET_VAL(1'b0)) u_mosi (
    .clk(clk), .reset(reset), .din(mosi_raw), .dout(mosi_c), .rise(mosi_rise), .fall(mosi_fall)
  );
  sync_debounce #(.DEBOUNCE(DEBOUNCE), .RESET_VAL(1'b1)) u_cs_n (
    .clk(clk), .reset(reset), .din(cs_n_raw), .dout(cs_n_c), .rise(cs_rise), .fall(cs_fall)
  );

  logic unused_cond;
  assign unused_cond = ^{sclk_c, mosi_rise, mosi_fall, cs_n_c};

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] tx_sr;
  logic [WIDTH-1:0] rx_sr;
  logic             pend_valid;
  logic [WIDTH-1:0] pend_data;

  logic             sample_edge;
  logic             shift_edge;
  logic             word_done;
  logic             load_now;
  logic             first_shift;
  logic [WIDTH-1:0] rx_next;
  logic [WIDTH-1:0] tx_next;

  assign sample_edge = (state == SHIFT) && !cs_rise && ((CPHA == 0) ? sclk_rise : sclk_fall);
  assign shift_edge  = (state == SHIFT) && !cs_rise && ((CPHA == 0) ? sclk_fall : sclk_rise);
  assign word_done   = sample_edge && (cnt == CW'(WIDTH - 1));
  assign load_now    = load && ((state == IDLE) || (cnt == '0));
  // With CPHA=0 the first bit is on the wire before the first clock; its shift edge is a no-op.
  assign first_shift = (CPHA == 0) && (cnt == '0);

  always_comb begin
    rx_next = rx_sr;
    tx_next = tx_sr;
    if (MSB_FIRST != 0) begin
      rx_next = {rx_sr[WIDTH-2:0], mosi_c};
      tx_next = {tx_sr[WIDTH-2:0], 1'b0};
    end else begin
      rx_next = {mosi_c, rx_sr[WIDTH-1:1]};
      tx_next = {1'b0, tx_sr[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state <= SHIFT;
            cnt   <= '0;
            rx_sr <= '0;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state <= IDLE;
            cnt   <= '0;
            rx_sr <= '0;
          end else if (sample_edge) begin
            rx_sr <= rx_next;
            if (word_done) begin
              cnt      <= '0;
              rx_data  <= rx_next;
              rx_valid <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // Transmit register: a load always beats a same-cycle shift.
      if (load_now) begin
        tx_sr <= load_data;
      end else if (word_done && (load || pend_valid)) begin
        tx_sr <= load ? load_data : pend_data;
      end else if ((state == SHIFT) && cs_rise && pend_valid) begin
        tx_sr <= pend_data;
`ifdef SPI_SLAVE_CORE_LOOPBACK_EN
      end else if (word_done) begin
        tx_sr <= rx_next;
`endif
      end else if (shift_edge && !first_shift) begin
        tx_sr <= tx_next;
      end

      if (load_now || word_done || ((state == SHIFT) && cs_rise)) begin
        pend_valid <= 1'b0;
      end else if (load) begin
        pend_valid <= 1'b1;
        pend_data  <= load_data;
      end
    end
  end

  assign miso = (MSB_FIRST != 0) ? tx_sr[WIDTH-1] : tx_sr[0];
  assign busy = (state == SHIFT);

endmodule

// File: tb/tb_spi_slave_core.sv
// tb/tb_spi_slave_core.sv - self-checking bench for spi_slave_core (WIDTH=8, DEBOUNCE=3, CPHA=0, MSB first)
module tb_spi_slave_core;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sclk_raw = 1'b0;
  logic       mosi_raw = 1'b0;
  logic       cs_n_raw = 1'b1;
  logic       load = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic       miso;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;

  int errors = 0;
  int checks = 0;

  logic [7:0] got_q[$];
  logic [7:0] last_rx = 8'h00;

  typedef struct {
    int              n;
    int              lpos;
    logic [2:0][7:0] tx;
    logic [2:0][7:0] rx;
  } vec_t;

  vec_t tbl[5];

  spi_slave_core dut (
    .clk(clk), .reset(reset), .sclk_raw(sclk_raw), .mosi_raw(mosi_raw), .cs_n_raw(cs_n_raw),
    .load(load), .load_data(load_data), .miso(miso), .rx_data(rx_data),
    .rx_valid(rx_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) got_q.push_back(rx_data);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input int n, input int lpos, input logic [7:0] t0, input logic [7:0] t1,
                              input logic [7:0] t2, input logic [7:0] r0, input logic [7:0] r1,
                              input logic [7:0] r2);
    vec_t v;
    v.n    = n;
    v.lpos = lpos;
    v.tx   = {t2, t1, t0};
    v.rx   = {r2, r1, r0};
    return v;
  endfunction

  task automatic load_word(input logic [7:0] w);
    load      = 1'b1;
    load_data = w;
    tick(1);
    load = 1'b0;
    tick(2);
  endtask

  // One bit: low phase (master drives data, optional load away from edges), then high phase.
  task automatic send_bit(input logic b, input logic do_load, input logic [7:0] lv, output logic m);
    mosi_raw = b;
    sclk_raw = 1'b0;
    tick(6);
    if (do_load) begin
      load      = 1'b1;
      load_data = lv;
    end
    tick(1);
    load = 1'b0;
    tick(1);
    m        = miso;
    sclk_raw = 1'b1;
    tick(8);
  endtask

  task automatic run_burst(input vec_t v);
    logic [7:0] mw;
    logic [7:0] nxt;
    logic       m;
    got_q.delete();
    load_word(v.tx[0]);
    cs_n_raw = 1'b0;
    tick(8);
    for (int j = 0; j < v.n; j++) begin
      mw  = 8'h00;
      nxt = (j < 2) ? v.tx[j+1] : 8'h00;
      for (int i = 0; i < 8; i++) begin
        send_bit(v.rx[j][7-i], (v.lpos != 0) && (i == v.lpos) && (j + 1 < v.n), nxt, m);
        mw = {mw[6:0], m};
      end
      check($sformatf("miso_word%0d", j), {24'h0, mw}, {24'h0, v.tx[j]});
    end
    sclk_raw = 1'b0;
    tick(8);
    cs_n_raw = 1'b1;
    tick(8);
    check("rx_valid_count", got_q.size(), v.n);
    for (int j = 0; j < v.n; j++) begin
      if (j < got_q.size()) check($sformatf("rx_word%0d", j), {24'h0, got_q[j]}, {24'h0, v.rx[j]});
    end
    check("busy_after_burst", {31'h0, busy}, 32'h0);
    last_rx = v.rx[v.n-1];
  endtask

  initial begin
    int   lat;
    logic moved;
    logic m;

    tbl[0] = mk(1, 0, 8'hA5, 8'h00, 8'h00, 8'h3C, 8'h00, 8'h00);
    tbl[1] = mk(2, 4, 8'h81, 8'h7E, 8'h00, 8'h12, 8'h34, 8'h00);
    tbl[2] = mk(2, 3, 8'hC3, 8'h0F, 8'h00, 8'hFF, 8'h00, 8'h00);
    tbl[3] = mk(1, 0, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00);
`ifdef SPI_SLAVE_CORE_LOOPBACK_EN
    tbl[4] = mk(2, 0, 8'hA5, 8'h5A, 8'h00, 8'h5A, 8'h11, 8'h00);
`else
    // Without loopback the register just keeps shifting: only A5's last bit remains at the top.
    tbl[4] = mk(2, 0, 8'hA5, 8'h80, 8'h00, 8'h5A, 8'h11, 8'h00);
`endif

    tick(4);
    check("reset_miso", {31'h0, miso}, 32'h0);
    check("reset_rx_data", {24'h0, rx_data}, 32'h0);
    check("reset_rx_valid", {31'h0, rx_valid}, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);
    reset = 1'b0;
    tick(10);

    // Debounce: a 2-cycle glitch is rejected, a held change appears 5 cycles after the raw edge.
    mosi_raw = 1'b1;
    tick(2);
    mosi_raw = 1'b0;
    moved = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      if (dut.u_mosi.dout) moved = 1'b1;
    end
    check("glitch_rejected", {31'h0, moved}, 32'h0);
    mosi_raw = 1'b1;
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      lat++;
      if (dut.u_mosi.dout) break;
    end
    check("mosi_latency", lat, 5);
    mosi_raw = 1'b0;
    tick(10);

    for (int t = 0; t < 5; t++) run_burst(tbl[t]);

    // Sclk activity while deselected, then an aborted 5-bit word.
    load_word(8'h96);
    for (int k = 0; k < 3; k++) begin
      sclk_raw = 1'b1;
      tick(8);
      sclk_raw = 1'b0;
      tick(8);
    end
    check("idle_sclk_busy", {31'h0, busy}, 32'h0);
    check("idle_sclk_miso", {31'h0, miso}, 32'h1);
    got_q.delete();
    cs_n_raw = 1'b0;
    tick(8);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0, 8'h00, m);
    check("partial_busy_high", {31'h0, busy}, 32'h1);
    sclk_raw = 1'b0;
    tick(8);
    cs_n_raw = 1'b1;
    tick(8);
    check("abort_no_rx_valid", got_q.size(), 0);
    check("abort_rx_data_kept", {24'h0, rx_data}, {24'h0, last_rx});
    check("abort_busy_low", {31'h0, busy}, 32'h0);
    run_burst(mk(1, 0, 8'h69, 8'h00, 8'h00, 8'hB7, 8'h00, 8'h00));

    // Randomised bursts with a pending load placed mid-word for every following word.
    for (int r = 0; r < 8; r++) begin
      run_burst(mk($urandom_range(1, 3), $urandom_range(1, 7), 8'($urandom), 8'($urandom),
                   8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)));
    end

    // Reset in the middle of a word.
    load_word(8'hFF);
    cs_n_raw = 1'b0;
    tick(8);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0, 8'h00, m);
    sclk_raw = 1'b0;
    tick(8);
    check("pre_reset_miso", {31'h0, miso}, 32'h1);
    reset    = 1'b1;
    cs_n_raw = 1'b1;
    mosi_raw = 1'b0;
    tick(1);
    check("midword_reset_miso", {31'h0, miso}, 32'h0);
    check("midword_reset_rx_data", {24'h0, rx_data}, 32'h0);
    check("midword_reset_rx_valid", {31'h0, rx_valid}, 32'h0);
    check("midword_reset_busy", {31'h0, busy}, 32'h0);
    tick(3);
    reset = 1'b0;
    tick(10);
    run_burst(mk(1, 0, 8'h3A, 8'h00, 8'h00, 8'hC5, 8'h00, 8'h00));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
